// File: rtl/uart_rx_engine_if.sv
// uart_rx_engine_if: register-block side bundle of the UART receive engine.
// The register block holds the master modport and the engine holds the slave modport.
// When UART_RX_PARITY_EN is defined, the bundle also carries the parity-select input
// and the parity-error pulse.
interface uart_rx_engine_if #(
    parameter int DIV_W = 32
);
    logic             en_i;
    logic [DIV_W-1:0] baud_div_i;
    logic [7:0]       rx_data_o;
    logic             rx_over_o;
    logic             frame_err_o;
    logic             busy_o;
`ifdef UART_RX_PARITY_EN
    logic             parity_odd_i;
    logic             parity_err_o;

    modport master (
        output en_i, baud_div_i, parity_odd_i,
        input  rx_data_o, rx_over_o, frame_err_o, busy_o, parity_err_o
    );
    modport slave (
        input  en_i, baud_div_i, parity_odd_i,
        output rx_data_o, rx_over_o, frame_err_o, busy_o, parity_err_o
    );
`else
    modport master (
        output en_i, baud_div_i,
        input  rx_data_o, rx_over_o, frame_err_o, busy_o
    );
    modport slave (
        input  en_i, baud_div_i,
        output rx_data_o, rx_over_o, frame_err_o, busy_o
    );
`endif
endinterface

// File: rtl/uart_rx_engine.sv
// uart_rx_engine: oversampling-free UART receiver (8N1, LSB first, idle-high line).
// Each bit lasts a programmable number of clocks. The start bit is confirmed at mid-bit.
// Each later bit is sampled one bit period after the previous sample.
// Optional feature macro: UART_RX_PARITY_EN inserts a parity bit between data and stop.
module uart_rx_engine #(
    parameter int DIV_W   = 32,
    parameter int MIN_DIV = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            uart_rx,
    uart_rx_engine_if.slave bus
);

    localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(MIN_DIV);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Even-parity bit of a data byte; odd parity is this value inverted.
    function automatic logic calc_parity(input logic [7:0] data);
        return ^data;
    endfunction

    state_t           state_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic [DIV_W-1:0] cnt_q;
    logic [2:0]       idx_q;
    logic [7:0]       shift_q;
    logic [7:0]       rx_data_q;
    logic             rx_over_q;
    logic             frame_err_q;
    logic             busy_q;
    logic             sync1_q;
    logic             sync2_q;
    logic             prev_q;
    logic             fall_s;
`ifdef UART_RX_PARITY_EN
    logic             par_odd_q;
    logic             par_bad_q;
    logic             parity_err_q;
`endif

    // Clamp the programmed divisor so that the mid-bit point is at least one clock in.
    always_comb begin
        div_d = (bus.baud_div_i < DIV_MIN) ? DIV_MIN : bus.baud_div_i;
    end

    assign fall_s = prev_q & ~sync2_q;

    // Two-flop synchronizer on the pad plus a history flop for falling-edge detection.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= uart_rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Receive FSM: bit timing, shifting, and the registered status pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            div_q        <= DIV_MIN;
            cnt_q        <= {DIV_W{1'b0}};
            idx_q        <= 3'd0;
            shift_q      <= 8'h00;
            rx_data_q    <= 8'h00;
            rx_over_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_odd_q    <= 1'b0;
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_over_q   <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            if ((state_q != ST_IDLE) && !bus.en_i) begin
                // Disabling the receiver drops the frame silently.
                state_q <= ST_IDLE;
                cnt_q   <= {DIV_W{1'b0}};
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        cnt_q <= {DIV_W{1'b0}};
                        if (bus.en_i && fall_s) begin
                            state_q <= ST_START;
                            div_q   <= div_d;
                            busy_q  <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            par_odd_q <= bus.parity_odd_i;
`endif
                        end
                    end
                    ST_START: begin
                        if (cnt_q == ((div_q >> 1) - DIV_ONE)) begin
                            cnt_q <= {DIV_W{1'b0}};
                            idx_q <= 3'd0;
                            if (sync2_q) begin
                                // Line is high again at mid-bit: treat as noise.
                                state_q <= ST_IDLE;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q <= ST_DATA;
                            end
                        end else begin
                            cnt_q <= cnt_q + DIV_ONE;
                        end
                    end
                    ST_DATA: begin
                        if (cnt_q == (div_q - DIV_ONE)) begin
                            cnt_q          <= {DIV_W{1'b0}};
                            shift_q[idx_q] <= sync2_q;
                            if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                state_q <= ST_PARITY;
`else
                                state_q <= ST_STOP;
`endif
                            end else begin
                                idx_q <= idx_q + 3'd1;
                            end
                        end else begin
                            cnt_q <= cnt_q + DIV_ONE;
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    ST_PARITY: begin
                        if (cnt_q == (div_q - DIV_ONE)) begin
                            cnt_q     <= {DIV_W{1'b0}};
                            par_bad_q <= sync2_q ^ calc_parity(shift_q) ^ par_odd_q;
                            state_q   <= ST_STOP;
                        end else begin
                            cnt_q <= cnt_q + DIV_ONE;
                        end
                    end
`endif
                    ST_STOP: begin
                        if (cnt_q == (div_q - DIV_ONE)) begin
                            cnt_q   <= {DIV_W{1'b0}};
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                            if (sync2_q) begin
                                rx_data_q <= shift_q;
                                rx_over_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
                                parity_err_q <= par_bad_q;
`endif
                            end else begin
                                frame_err_q <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + DIV_ONE;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        cnt_q   <= {DIV_W{1'b0}};
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.rx_data_o   = rx_data_q;
    assign bus.rx_over_o   = rx_over_q;
    assign bus.frame_err_o = frame_err_q;
    assign bus.busy_o      = busy_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err_o = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_engine.sv
// tb_uart_rx_engine: directed bench for uart_rx_engine with hand-computed expectations.
module tb_uart_rx_engine;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic rx_line = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    int ferr_cnt    = 0;
    int busy_cycles = 0;
    int both_cnt    = 0;
    int perr_cnt    = 0;
    logic [7:0] got_q[$];

    int base_n;
    int base_f;
    int base_b;

    uart_rx_engine_if #(.DIV_W(32)) bus();

    uart_rx_engine #(.DIV_W(32), .MIN_DIV(4)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .uart_rx (rx_line),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Pulse and busy monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (bus.rx_over_o === 1'b1) got_q.push_back(bus.rx_data_o);
        if (bus.frame_err_o === 1'b1) ferr_cnt <= ferr_cnt + 1;
        if (bus.busy_o === 1'b1) busy_cycles <= busy_cycles + 1;
        if ((bus.rx_over_o === 1'b1) && (bus.frame_err_o === 1'b1)) both_cnt <= both_cnt + 1;
`ifdef UART_RX_PARITY_EN
        if (bus.parity_err_o === 1'b1) perr_cnt <= perr_cnt + 1;
`endif
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one frame; new_div != 0 rewrites baud_div_i after the start bit.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int div,
                              input int new_div, input logic flip_par);
        @(posedge clk); #1;
        rx_line = 1'b0;
        repeat (div) @(posedge clk);
        #1;
        if (new_div != 0) bus.baud_div_i = new_div;
        for (int i = 0; i < 8; i++) begin
            rx_line = data[i];
            repeat (div) @(posedge clk);
            #1;
        end
`ifdef UART_RX_PARITY_EN
        rx_line = (^data) ^ bus.parity_odd_i ^ flip_par;
        repeat (div) @(posedge clk);
        #1;
`else
        if (flip_par) rx_line = 1'b1;
`endif
        rx_line = stop_bit;
        repeat (div) @(posedge clk);
        #1;
        rx_line = 1'b1;
    endtask

    initial begin
        bus.en_i       = 1'b1;
        bus.baud_div_i = 32'd8;
`ifdef UART_RX_PARITY_EN
        bus.parity_odd_i = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data", {24'h0, bus.rx_data_o}, 32'h00);
        check("rst_over", {31'h0, bus.rx_over_o}, 32'h0);
        check("rst_ferr", {31'h0, bus.frame_err_o}, 32'h0);
        check("rst_busy", {31'h0, bus.busy_o}, 32'h0);
        rst = 1'b0;
        repeat (5) @(posedge clk);

        // Plain 0xA5 at div 8: 4 start + 64 data (+8 parity) + 8 stop busy cycles.
        base_n = got_q.size(); base_f = ferr_cnt; base_b = busy_cycles;
        send_frame(8'hA5, 1'b1, 8, 0, 1'b0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("a5_count", got_q.size() - base_n, 32'd1);
        if (got_q.size() > base_n) check("a5_data", {24'h0, got_q[base_n]}, 32'hA5);
        check("a5_reg", {24'h0, bus.rx_data_o}, 32'hA5);
        check("a5_ferr", ferr_cnt - base_f, 32'd0);
`ifdef UART_RX_PARITY_EN
        check("a5_busy", busy_cycles - base_b, 32'd84);
`else
        check("a5_busy", busy_cycles - base_b, 32'd76);
`endif

        // 0x3C with a bad stop bit.
        base_n = got_q.size(); base_f = ferr_cnt;
        send_frame(8'h3C, 1'b0, 8, 0, 1'b0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("ferr_count", ferr_cnt - base_f, 32'd1);
        check("ferr_over", got_q.size() - base_n, 32'd0);
        check("ferr_keep", {24'h0, bus.rx_data_o}, 32'hA5);

        // Two-cycle glitch at div 16: 8 START cycles then back to idle.
        bus.baud_div_i = 32'd16;
        base_n = got_q.size(); base_f = ferr_cnt; base_b = busy_cycles;
        @(posedge clk); #1;
        rx_line = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rx_line = 1'b1;
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("glitch_busy", {31'h0, bus.busy_o}, 32'h0);
        check("glitch_bcyc", busy_cycles - base_b, 32'd8);
        check("glitch_pulses", (got_q.size() - base_n) + (ferr_cnt - base_f), 32'd0);

        // Back-to-back at divisor 2, clamped to 4.
        bus.baud_div_i = 32'd2;
        base_n = got_q.size();
        send_frame(8'h00, 1'b1, 4, 0, 1'b0);
        send_frame(8'hFF, 1'b1, 4, 0, 1'b0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("b2b_count", got_q.size() - base_n, 32'd2);
        if (got_q.size() > base_n + 1) begin
            check("b2b_first", {24'h0, got_q[base_n]}, 32'h00);
            check("b2b_second", {24'h0, got_q[base_n + 1]}, 32'hFF);
        end

        // Reset during bit 3 of 0x81, then 0x42.
        bus.baud_div_i = 32'd8;
        base_n = got_q.size();
        @(posedge clk); #1;
        rx_line = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            rx_line = (i == 0) ? 1'b1 : 1'b0;
            repeat (8) @(posedge clk);
            #1;
        end
        rx_line = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        rx_line = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("mrst_data", {24'h0, bus.rx_data_o}, 32'h00);
        check("mrst_busy", {31'h0, bus.busy_o}, 32'h0);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        send_frame(8'h42, 1'b1, 8, 0, 1'b0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("mrst_count", got_q.size() - base_n, 32'd1);
        if (got_q.size() > base_n) check("mrst_42", {24'h0, got_q[base_n]}, 32'h42);

        // Held-low break gives exactly one framing error.
        base_n = got_q.size(); base_f = ferr_cnt;
        @(posedge clk); #1;
        rx_line = 1'b0;
        repeat (250) @(posedge clk);
        #1;
        rx_line = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("break_ferr", ferr_cnt - base_f, 32'd1);
        check("break_over", got_q.size() - base_n, 32'd0);

        // Disable mid-frame.
        base_n = got_q.size(); base_f = ferr_cnt;
        @(posedge clk); #1;
        rx_line = 1'b0;
        repeat (24) @(posedge clk);
        #1;
        bus.en_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("dis_busy", {31'h0, bus.busy_o}, 32'h0);
        rx_line = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        bus.en_i = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("dis_pulses", (got_q.size() - base_n) + (ferr_cnt - base_f), 32'd0);
        check("dis_keep", {24'h0, bus.rx_data_o}, 32'h42);

        // Divisor rewritten mid-frame has no effect on the current frame.
        base_n = got_q.size();
        send_frame(8'h5A, 1'b1, 8, 20, 1'b0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("divchg_count", got_q.size() - base_n, 32'd1);
        if (got_q.size() > base_n) check("divchg_data", {24'h0, got_q[base_n]}, 32'h5A);
        bus.baud_div_i = 32'd8;

`ifdef UART_RX_PARITY_EN
        // Odd parity, 0x07 with parity bit 1 (correct bit is 0).
        check("par_clean", perr_cnt, 32'd0);
        bus.parity_odd_i = 1'b1;
        base_n = got_q.size();
        send_frame(8'h07, 1'b1, 8, 0, 1'b1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("par_err", perr_cnt, 32'd1);
        check("par_count", got_q.size() - base_n, 32'd1);
        check("par_data", {24'h0, bus.rx_data_o}, 32'h07);
`endif

        check("never_both", both_cnt, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
